// File: rtl/drp_responder_if.sv
// DRP request/response bundle between a DRP master and a DRP endpoint.
// Latency: none, this is wiring only.
// Backpressure: none. The master issues single-cycle drp_en pulses and waits for drp_rdy.
interface drp_responder_if #(
  parameter int ADDR_W = 10
) ();
  logic              drp_en;
  logic              drp_we;
  logic [ADDR_W-1:0] drp_addr;
  logic [15:0]       drp_di;
  logic              drp_rdy;
  logic [15:0]       drp_do;

  modport master (
    output drp_en, drp_we, drp_addr, drp_di,
    input  drp_rdy, drp_do
  );

  modport slave (
    input  drp_en, drp_we, drp_addr, drp_di,
    output drp_rdy, drp_do
  );
endinterface

// File: rtl/drp_responder.sv
// DRP endpoint with a bank of R/W control registers followed by a window of read-only status words.
// Latency: drp_rdy arrives exactly RD_LAT (reads) or WR_LAT (writes) cycles after the accepted drp_en.
// Backpressure: one transaction at a time. drp_en while busy is dropped and flagged on err_overlap_o.
module drp_responder #(
  parameter int                ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 10'h040,
  parameter int                NUM_REGS     = 16,
  parameter int                NUM_STAT     = 4,
  parameter int                RD_LAT       = 2,
  parameter int                WR_LAT       = 1,
  parameter logic [15:0]       UNMAPPED_VAL = 16'hDEAD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  drp_responder_if.slave         drp,
  input  logic [NUM_STAT*16-1:0] stat_in_i,
  output logic [NUM_REGS*16-1:0] reg_out_o,
  output logic [NUM_REGS-1:0]    wr_strobe_o,
  output logic                   err_unmapped_o,
  output logic                   err_overlap_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  int                lat;

  // Transaction captured at acceptance; the request bus is free after that.
  logic              we_q;
  logic              is_reg_q;
  logic              unmapped_q;
  logic [ADDR_W-1:0] off_q;
  logic [15:0]       di_q;
  logic [15:0]       snap_q;
  logic              err_ovl_q;

  logic [15:0]       regs_q [NUM_REGS];

  // Address decode for the request currently on the bus.
  logic              in_range;
  logic [ADDR_W-1:0] off;
  logic              dec_reg;
  logic              dec_stat;
  logic [15:0]       rd_data;

  // Decode the offset and select the read data. Addresses below BASE_ADDR never wrap into the map.
  always_comb begin
    in_range = (drp.drp_addr >= BASE_ADDR);
    off      = drp.drp_addr - BASE_ADDR;
    dec_reg  = in_range && (off < ADDR_W'(NUM_REGS));
    dec_stat = in_range && !dec_reg && (off < ADDR_W'(NUM_REGS + NUM_STAT));
    rd_data  = UNMAPPED_VAL;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_reg && (off == ADDR_W'(i))) rd_data = regs_q[i];
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (dec_stat && (off == ADDR_W'(NUM_REGS + k))) rd_data = stat_in_i[16*k +: 16];
    end
  end

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a latency of 1 skips WAIT. Otherwise WAIT counts down until RESP lands on cycle N+LAT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    lat     = drp.drp_we ? WR_LAT : RD_LAT;
    case (state_q)
      S_IDLE: begin
        if (drp.drp_en) begin
          accept  = 1'b1;
          cnt_d   = 4'(lat - 1);
          state_d = (lat == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs depend only on flops. Write data is committed at the end of the RESP cycle.
  always_comb begin
    drp.drp_rdy    = (state_q == S_RESP);
    drp.drp_do     = (state_q == S_RESP && !we_q) ? snap_q : 16'h0000;
    err_unmapped_o = (state_q == S_RESP) && unmapped_q;
    err_overlap_o  = err_ovl_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_strobe_o[i]         = (state_q == S_RESP) && we_q && is_reg_q && (off_q == ADDR_W'(i));
      reg_out_o[16*i +: 16]  = regs_q[i];
    end
  end

  // Capture the request and snapshot the read data on the acceptance cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      is_reg_q   <= 1'b0;
      unmapped_q <= 1'b0;
      off_q      <= '0;
      di_q       <= '0;
      snap_q     <= '0;
    end else if (accept) begin
      we_q       <= drp.drp_we;
      is_reg_q   <= dec_reg;
      unmapped_q <= !dec_reg && !dec_stat;
      off_q      <= off;
      di_q       <= drp.drp_di;
      snap_q     <= drp.drp_we ? 16'h0000 : rd_data;
    end
  end

  // A request arriving while busy is dropped and reported one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_ovl_q <= 1'b0;
    else        err_ovl_q <= drp.drp_en && (state_q != S_IDLE);
  end

  // Register bank. Reset during a transaction leaves the bank cleared with no commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_strobe_o[i]) regs_q[i] <= di_q;
      end
    end
  end

endmodule

// File: tb/tb_drp_responder.sv
// Randomized scoreboard bench for drp_responder with a transaction-level reference model.
// Latency: expected drp_rdy cycles are computed from RD_LAT/WR_LAT at issue time.
// Backpressure: requests issued while the model is busy are expected to be dropped and flagged.
module tb_drp_responder;
  localparam int BASE = 'h040;
  localparam int NREG = 16;
  localparam int NSTAT = 4;
  localparam int RLAT = 2;
  localparam int WLAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSTAT*16-1:0] stat_in;
  logic [NREG*16-1:0]  reg_out;
  logic [NREG-1:0]     wr_strobe;
  logic                err_unmapped, err_overlap;
  logic [15:0]         stat_words [NSTAT];

  drp_responder_if #(.ADDR_W(10)) drp_bus ();

  drp_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .drp            (drp_bus),
    .stat_in_i      (stat_in),
    .reg_out_o      (reg_out),
    .wr_strobe_o    (wr_strobe),
    .err_unmapped_o (err_unmapped),
    .err_overlap_o  (err_overlap)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NSTAT; k++) stat_in[16*k +: 16] = stat_words[k];
  end

  typedef struct { int cyc; logic [15:0] data; bit unm; logic [15:0] strobe; } exp_t;
  typedef struct { int eff; int idx; logic [15:0] val; } pend_t;

  exp_t        expq [$];
  pend_t       pend [$];
  bit          ovl_exp [int];
  logic [15:0] model_regs [NREG];
  logic [15:0] ref_vis [NREG];
  int          busy_until = -1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    expq.delete();
    pend.delete();
    ovl_exp.delete();
    for (int i = 0; i < NREG; i++) begin
      model_regs[i] = '0;
      ref_vis[i]    = '0;
    end
    busy_until = -1;
  endtask

  // Drive one drp_en pulse in the current cycle and record what the endpoint must answer.
  task automatic issue(input bit we, input int a, input logic [15:0] d);
    int c;
    int lat;
    exp_t e;
    c = cyc;
    drp_bus.drp_en   = 1'b1;
    drp_bus.drp_we   = we;
    drp_bus.drp_addr = 10'(a);
    drp_bus.drp_di   = d;
    if (c > busy_until) begin
      lat      = we ? WLAT : RLAT;
      e.cyc    = c + lat;
      e.data   = 16'h0000;
      e.unm    = 1'b0;
      e.strobe = '0;
      if (a >= BASE && a < BASE + NREG) begin
        if (we) begin
          model_regs[a-BASE] = d;
          e.strobe[a-BASE]   = 1'b1;
          pend.push_back('{eff: c + lat + 1, idx: a - BASE, val: d});
        end else begin
          e.data = model_regs[a-BASE];
        end
      end else if (a >= BASE + NREG && a < BASE + NREG + NSTAT) begin
        if (!we) e.data = stat_words[a-BASE-NREG];
      end else begin
        e.unm = 1'b1;
        if (!we) e.data = 16'hDEAD;
      end
      expq.push_back(e);
      busy_until = c + lat;
    end else begin
      ovl_exp[c+1] = 1'b1;
    end
    step();
    drp_bus.drp_en   = 1'b0;
    drp_bus.drp_we   = 1'($urandom);
    drp_bus.drp_addr = 10'($urandom);
    drp_bus.drp_di   = 16'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc <= busy_until) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    clear_model();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle against the scoreboard and the visible-register model.
  always @(negedge clk) begin
    logic [255:0] vis;
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs",
          !drp_bus.drp_rdy && drp_bus.drp_do == 16'h0 && reg_out == '0 && wr_strobe == '0
          && !err_unmapped && !err_overlap,
          {drp_bus.drp_rdy, drp_bus.drp_do, wr_strobe, err_unmapped, err_overlap}, 256'h0);
    end else begin
      while (pend.size() > 0 && pend[0].eff <= cyc) begin
        ref_vis[pend[0].idx] = pend[0].val;
        void'(pend.pop_front());
      end
      for (int i = 0; i < NREG; i++) vis[16*i +: 16] = ref_vis[i];
      chk("reg_out", reg_out == vis, reg_out, vis);
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        chk("missing_rdy", 1'b0, 256'(cyc), 256'(expq[0].cyc));
        void'(expq.pop_front());
      end
      if (drp_bus.drp_rdy) begin
        if (expq.size() == 0) begin
          chk("spurious_rdy", 1'b0, 256'(1), 256'(0));
        end else begin
          e = expq.pop_front();
          chk("rdy_cycle", cyc == e.cyc, 256'(cyc), 256'(e.cyc));
          chk("drp_do", drp_bus.drp_do == e.data, 256'(drp_bus.drp_do), 256'(e.data));
          chk("err_unmapped", err_unmapped == e.unm, 256'(err_unmapped), 256'(e.unm));
          chk("wr_strobe", wr_strobe == e.strobe, 256'(wr_strobe), 256'(e.strobe));
        end
      end else begin
        chk("idle_outputs", drp_bus.drp_do == 16'h0 && wr_strobe == '0 && !err_unmapped,
            {drp_bus.drp_do, wr_strobe, err_unmapped}, 256'h0);
      end
      chk("err_overlap", err_overlap == ovl_exp.exists(cyc), 256'(err_overlap), 256'(ovl_exp.exists(cyc)));
    end
  end

  initial begin
    int c0;
    int a;
    drp_bus.drp_en   = 1'b0;
    drp_bus.drp_we   = 1'b0;
    drp_bus.drp_addr = '0;
    drp_bus.drp_di   = '0;
    for (int k = 0; k < NSTAT; k++) stat_words[k] = 16'($urandom);
    clear_model();
    #1;
    do_reset(3);

    // Basic read of an untouched register.
    issue(1'b0, 'h040, 16'h0);
    wait_idle();

    // Write then read back register 5.
    issue(1'b1, 'h045, 16'hA5C3);
    wait_idle();
    @(negedge clk);
    chk("reg5_direct", reg_out[95:80] == 16'hA5C3, 256'(reg_out[95:80]), 256'hA5C3);
    step();
    issue(1'b0, 'h045, 16'h0);
    wait_idle();

    // Status window is read-only.
    stat_words[2] = 16'h1234;
    issue(1'b0, 'h052, 16'h0);
    wait_idle();
    issue(1'b1, 'h052, 16'hFFFF);
    wait_idle();
    issue(1'b0, 'h052, 16'h0);
    wait_idle();

    // Unmapped below, above, and at the top of the address space.
    issue(1'b0, 'h03F, 16'h0);
    wait_idle();
    issue(1'b0, 'h054, 16'h0);
    wait_idle();
    issue(1'b1, 'h3FF, 16'hBEEF);
    wait_idle();

    // Overlap: second request one cycle later is dropped; next idle cycle is accepted.
    c0 = cyc;
    issue(1'b0, 'h045, 16'h0);
    issue(1'b0, 'h040, 16'h0);
    wait_idle();
    chk("first_idle_cycle", cyc == c0 + RLAT + 1, 256'(cyc), 256'(c0 + RLAT + 1));
    issue(1'b1, 'h046, 16'h5A5A);
    wait_idle();

    // Reset while the write is in flight aborts it.
    issue(1'b1, 'h041, 16'h00FF);
    do_reset(2);
    issue(1'b0, 'h041, 16'h0);
    wait_idle();
    @(negedge clk);
    chk("reg1_after_reset", reg_out[31:16] == 16'h0000, 256'(reg_out[31:16]), 256'h0);
    step();

    // Randomized traffic with random spacing, including overlapping requests.
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 9) == 0) stat_words[$urandom_range(0, NSTAT-1)] = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = BASE + $urandom_range(0, NREG-1);
        1: a = BASE + NREG + $urandom_range(0, NSTAT-1);
        2: a = $urandom_range('h030, 'h05F);
        default: a = $urandom_range(0, 1023);
      endcase
      issue(1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // Drain outstanding responses with a bounded wait.
    for (int t = 0; t < 50 && expq.size() > 0; t++) step();
    repeat (3) step();
    chk("drain", expq.size() == 0, 256'(expq.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
